// File: rtl/tick_clr_gen_pkg.sv
// Shared definitions for the tick/clear generator: default clock and tick
// rates, the debounce FSM state encoding, and the debounce length helper.
package tick_clr_gen_pkg;

  localparam int unsigned DEF_CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_COUNT_HZ    = 1;
  localparam int unsigned DEF_SCAN_HZ     = 1000;
  localparam int unsigned DEF_DEBOUNCE_MS = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  // Number of clock cycles the synchronized button must stay stable.
  function automatic int unsigned db_cycles(input int unsigned clk_hz,
                                            input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/tick_clr_gen_tick_div.sv
// Free-running prescaler: registered one-cycle tick every N clocks.
// sync_zero restarts the period and suppresses a tick that would fire on that edge.
module tick_div #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic sync_zero,
  output logic tick
);

  localparam int unsigned W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + W'(1);
    tick_d = 1'b0;
    if (sync_zero) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tick_clr_gen.sv
// Count/scan tick generator with a debounced clear button; a qualified press
// emits one clr_pulse and restarts the count prescaler so the cleared digit gets a full period.
module tick_clr_gen
  import tick_clr_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned COUNT_HZ    = DEF_COUNT_HZ,
  parameter int unsigned SCAN_HZ     = DEF_SCAN_HZ,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_in,
  output logic count_tick,
  output logic scan_tick,
  output logic clr_pulse,
  output logic clr_level
);

  localparam int unsigned N_CNT  = CLK_HZ / COUNT_HZ;
  localparam int unsigned N_SCAN = CLK_HZ / SCAN_HZ;
  localparam int unsigned DB     = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned DBW    = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB - 1);

  logic [1:0]     sync_q, sync_d;
  logic           btn_s;
  db_state_e      state_q, state_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           clr_pulse_q, clr_pulse_d;
  logic           clr_level_q, clr_level_d;

  // Two-flop synchronizer; only btn_s feeds the debounce logic.
  always_comb begin
    sync_d = {sync_q[0], btn_in};
  end

  assign btn_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    clr_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = DBW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = HELD;
          clr_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d  = REL_WAIT;
          db_cnt_d = DBW'(1);
        end
      end
      REL_WAIT: begin
        // A bounce back to 1 returns to HELD without a second pulse.
        if (btn_s) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    clr_level_d = (state_d == HELD) || (state_d == REL_WAIT);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      clr_pulse_q <= 1'b0;
      clr_level_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      clr_pulse_q <= clr_pulse_d;
      clr_level_q <= clr_level_d;
    end
  end

  tick_div #(.N(N_CNT)) u_count_div (
    .clk      (clk),
    .clr      (clr),
    .sync_zero(clr_pulse_q),
    .tick     (count_tick)
  );

  tick_div #(.N(N_SCAN)) u_scan_div (
    .clk      (clk),
    .clr      (clr),
    .sync_zero(1'b0),
    .tick     (scan_tick)
  );

  assign clr_pulse = clr_pulse_q;
  assign clr_level = clr_level_q;

endmodule

// File: tb/tb_tick_clr_gen.sv
// Self-checking bench for tick_clr_gen at CLK_HZ=1000, COUNT_HZ=10, SCAN_HZ=250,
// DEBOUNCE_MS=5 (N_CNT=100, N_SCAN=4, DB=5).
module tb_tick_clr_gen;

  localparam int N_CNT  = 100;
  localparam int N_SCAN = 4;

  typedef struct packed {
    logic count_tick;
    logic scan_tick;
    logic clr_pulse;
    logic clr_level;
  } out_t;

  logic clk, clr, btn_in;
  logic count_tick, scan_tick, clr_pulse, clr_level;

  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   cyc = 0;
  int   cnt_base = 0;
  int   pulse_edge = -1;
  int   lvl_on = -1;
  int   lvl_off = -1;
  out_t exp_q[$];

  tick_clr_gen #(
    .CLK_HZ     (1000),
    .COUNT_HZ   (10),
    .SCAN_HZ    (250),
    .DEBOUNCE_MS(5)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_in    (btn_in),
    .count_tick(count_tick),
    .scan_tick (scan_tick),
    .clr_pulse (clr_pulse),
    .clr_level (clr_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after edge k: ticks are counted from the last prescaler
  // restart, pulse/level come from the press plan set by the running test.
  task automatic drive_cycle(input logic b);
    out_t e;
    int   k;
    btn_in = b;
    k = cyc + 1;
    e.count_tick = (k > cnt_base) && (((k - cnt_base) % N_CNT) == 0);
    e.scan_tick  = ((k % N_SCAN) == 0);
    e.clr_pulse  = (k == pulse_edge);
    e.clr_level  = (lvl_on >= 0) && (k >= lvl_on) && (k < lvl_off);
    exp_q.push_back(e);
    if (k == pulse_edge) cnt_base = k + 1;
    @(posedge clk);
    cyc = k;
    @(negedge clk);
  endtask

  task automatic release_clr();
    @(negedge clk);
    clr = 1'b0;
    cyc = 0;
    cnt_base = 0;
    pulse_edge = -1;
    lvl_on = -1;
    lvl_off = -1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    out_t got;
    clr = 1'b0;
    btn_in = 1'b0;
    #2 clr = 1'b1;
    #1;
    got = {count_tick, scan_tick, clr_pulse, clr_level};
    check_cnt++;
    if (got !== 4'b0000) $display("[TB] FAIL reset_async got=%b exp=0000", got);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    got = {count_tick, scan_tick, clr_pulse, clr_level};
    check_cnt++;
    if (got !== 4'b0000) $display("[TB] FAIL reset_held got=%b exp=0000", got);
    else pass_cnt++;
    release_clr();
  endtask

  task automatic test_free_run();
    out_t got, exp;
    int   n_cnt_ticks = 0, n_scan_ticks = 0, n_pulses = 0;
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'b0);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      n_cnt_ticks  += int'(count_tick);
      n_scan_ticks += int'(scan_tick);
      n_pulses     += int'(clr_pulse);
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL free_run cyc=%0d got(cnt,scan,pulse,lvl)=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (n_cnt_ticks !== 4) $display("[TB] FAIL free_run_count_ticks got=%0d exp=4", n_cnt_ticks);
    else pass_cnt++;
    check_cnt++;
    if (n_scan_ticks !== 100) $display("[TB] FAIL free_run_scan_ticks got=%0d exp=100", n_scan_ticks);
    else pass_cnt++;
    check_cnt++;
    if (n_pulses !== 0) $display("[TB] FAIL free_run_pulses got=%0d exp=0", n_pulses);
    else pass_cnt++;
  endtask

  task automatic test_bounce_reject();
    out_t got, exp;
    pulse_edge = -1;
    lvl_on = -1;
    lvl_off = -1;
    for (int i = 0; i < 15; i++) begin
      drive_cycle(i < 3);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL bounce_reject cyc=%0d got=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_press_hold();
    out_t got, exp;
    int   e_edge = cyc + 1;
    int   n_pulses = 0;
    pulse_edge = e_edge + 6;
    lvl_on = e_edge + 6;
    lvl_off = e_edge + 20 + 6;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(i < 20);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      n_pulses += int'(clr_pulse);
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL press_hold cyc=%0d got=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (n_pulses !== 1) $display("[TB] FAIL press_hold_pulses got=%0d exp=1", n_pulses);
    else pass_cnt++;
  endtask

  task automatic test_release_bounce();
    out_t got, exp;
    logic pat [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   e_edge = cyc + 1;
    int   r0 = e_edge + 12;
    int   n_pulses = 0;
    logic b;
    pulse_edge = e_edge + 6;
    lvl_on = e_edge + 6;
    lvl_off = r0 + 8 + 6;
    for (int i = 0; i < 35; i++) begin
      if (i < 12) b = 1'b1;
      else if (i < 20) b = pat[i-12];
      else b = 1'b0;
      drive_cycle(b);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      n_pulses += int'(clr_pulse);
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL release_bounce cyc=%0d got=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (n_pulses !== 1) $display("[TB] FAIL release_bounce_pulses got=%0d exp=1", n_pulses);
    else pass_cnt++;
  endtask

  task automatic test_coincide();
    out_t got, exp;
    int   e_edge;
    int   p_edge;
    // Idle until a press starting next edge lands its pulse on count counter 99.
    while (((cyc + 7 - cnt_base) % N_CNT) != (N_CNT - 1)) begin
      drive_cycle(1'b0);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL coincide_idle cyc=%0d got=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
    end
    e_edge = cyc + 1;
    p_edge = e_edge + 6;
    pulse_edge = p_edge;
    lvl_on = p_edge;
    lvl_off = e_edge + 15 + 6;
    for (int i = 0; i < 115; i++) begin
      drive_cycle(i < 15);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL coincide cyc=%0d got=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
      if (cyc == p_edge + 1) begin
        check_cnt++;
        if (count_tick !== 1'b0) $display("[TB] FAIL coincide_suppressed got=%b exp=0", count_tick);
        else pass_cnt++;
      end
      if (cyc == p_edge + 1 + N_CNT) begin
        check_cnt++;
        if (count_tick !== 1'b1) $display("[TB] FAIL coincide_next_tick got=%b exp=1", count_tick);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_clr_mid_press();
    out_t got, exp;
    int   n_pulses = 0;
    pulse_edge = -1;
    lvl_on = -1;
    lvl_off = -1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL clr_mid_press_pre cyc=%0d got=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
    end
    #2 clr = 1'b1;
    #1;
    got = {count_tick, scan_tick, clr_pulse, clr_level};
    check_cnt++;
    if (got !== 4'b0000) $display("[TB] FAIL clr_mid_press_async got=%b exp=0000", got);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    release_clr();
    pulse_edge = 7;
    lvl_on = 7;
    lvl_off = 20 + 6 + 1;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(i < 20);
      exp = exp_q.pop_front();
      got = {count_tick, scan_tick, clr_pulse, clr_level};
      n_pulses += int'(clr_pulse);
      check_cnt++;
      if (got !== exp) $display("[TB] FAIL clr_mid_press cyc=%0d got=%b exp=%b", cyc, got, exp);
      else pass_cnt++;
    end
    check_cnt++;
    if (n_pulses !== 1) $display("[TB] FAIL clr_mid_press_pulses got=%0d exp=1", n_pulses);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_bounce_reject();
    test_press_hold();
    test_release_bounce();
    test_coincide();
    test_clr_mid_press();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/tick_clr_gen.md
TICK_CLR_GEN -- requirements
Module: tick_clr_gen

Interface
REQ-001 Parameter CLK_HZ, default 50000000, board clock frequency in Hz.
REQ-002 Parameter COUNT_HZ, default 1, count-tick rate in Hz; N_CNT = CLK_HZ/COUNT_HZ.
REQ-003 Parameter SCAN_HZ, default 1000, display-refresh tick rate in Hz; N_SCAN = CLK_HZ/SCAN_HZ.
REQ-004 Parameter DEBOUNCE_MS, default 10, button stable time; DB = CLK_HZ/1000*DEBOUNCE_MS cycles.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-high.
REQ-007 btn_in  input  1  raw, asynchronous, bouncing clear pushbutton (1 = pressed).
REQ-008 count_tick  output  1  one-cycle pulse at COUNT_HZ; enables the downstream digit counter.
REQ-009 scan_tick  output  1  one-cycle pulse at SCAN_HZ; advances the downstream anode scan.
REQ-010 clr_pulse  output  1  one-cycle pulse per debounced press; synchronous clear for the digit counter.
REQ-011 clr_level  output  1  debounced button level (1 while the press is held).

Function
REQ-012 Count prescaler: counter 0..N_CNT-1, wraps to 0; count_tick = 1 exactly in cycles where counter == N_CNT-1.
REQ-013 Scan prescaler: identical behaviour with N_SCAN; free-running, never affected by clr_pulse.
REQ-014 First count_tick/scan_tick is registered N_CNT/N_SCAN cycles after clr deassertion, then strictly periodic.
REQ-015 Prescaler counter width = $clog2(N); no overflow past N-1 permitted.
REQ-016 btn_in passes a 2-flop synchronizer to btn_s before any use; btn_in is never used directly.
REQ-017 Debounce FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT; stable-count register db_cnt, width $clog2(DB).
REQ-018 IDLE: btn_s=1 -> PRESS_WAIT, db_cnt=1; else stay.
REQ-019 PRESS_WAIT: btn_s=0 -> IDLE (bounce rejected); btn_s=1 and db_cnt==DB-1 -> HELD with clr_pulse=1 for one cycle; else db_cnt+1.
REQ-020 HELD: btn_s=0 -> REL_WAIT, db_cnt=1; else stay (no repeat pulses).
REQ-021 REL_WAIT: btn_s=1 -> HELD (release bounce rejected, no new pulse); btn_s=0 and db_cnt==DB-1 -> IDLE; else db_cnt+1.
REQ-022 clr_level = 1 in HELD and REL_WAIT, 0 otherwise; all outputs registered.
REQ-023 Latency: btn_in first sampled 1 at edge E and held -> clr_pulse high in the cycle after edge E+DB+1.
REQ-024 clr_pulse restarts the count prescaler: counter = 0 in the cycle after clr_pulse, so the cleared digit is shown for a full count period.
REQ-025 clr_pulse coincident with count counter == N_CNT-1: count_tick suppressed that cycle; next count_tick N_CNT cycles later.
REQ-026 Parameters are legal only if COUNT_HZ < SCAN_HZ <= CLK_HZ/2 and DB >= 2; other values are unsupported.

Reset
REQ-027 clr=1 forces immediately, independent of clk: count_tick=0, scan_tick=0, clr_pulse=0, clr_level=0, both prescaler counters 0, synchronizer flops 0, FSM IDLE, db_cnt 0.
REQ-028 clr asserted mid-press discards debounce progress; a still-held button after release of clr requires a full DB-cycle qualification and yields exactly one clr_pulse.

Structure
REQ-029 Shared package/include holds the FSM state encodings and the default CLK_HZ, COUNT_HZ, SCAN_HZ, DEBOUNCE_MS values.
REQ-030 One sub-module tick_div (parameter N, inputs clk, clr, sync_zero; output tick) is instantiated twice; synchronizer and FSM stay in tick_clr_gen.

Verification (CLK_HZ=1000, COUNT_HZ=10, SCAN_HZ=250, DEBOUNCE_MS=5: N_CNT=100, N_SCAN=4, DB=5)
REQ-031 Release clr, run 400 cycles, btn_in=0 -> count_tick single-cycle at cycles 100,200,300,400; scan_tick every 4 cycles (100 pulses); clr_pulse never asserted.
REQ-032 btn_in high 3 cycles then low -> no clr_pulse, clr_level stays 0, FSM returns to IDLE.
REQ-033 btn_in high from edge E for 20 cycles -> exactly one clr_pulse, in the cycle after edge E+6; clr_level 1 from the same cycle until DB cycles after btn_s falls.
REQ-034 Release bounce (1-0-1-0 at 2-cycle spacing, then steady 0) -> no second clr_pulse; clr_level falls once, 5 stable cycles after the last bounce.
REQ-035 Press timed so clr_pulse coincides with count counter == 99 -> no count_tick in that cycle; next count_tick exactly 100 cycles later; scan_tick phase unchanged.
REQ-036 Assert clr for 2 cycles during PRESS_WAIT with btn_in held -> all outputs 0 at once; after clr release, clr_pulse arrives only after a fresh 2+5-cycle qualification.
